// File: rtl/slv_regfile.sv
// slv_regfile: BAR-mapped RW control / RO status register block with a doorbell handshake on the 16-bit slave bus.
// Optional interrupt status (W1C) and mask words at DB_ADR+1/+2 when SLV_REGFILE_IRQ_EN is defined.
module slv_regfile #(
  parameter int unsigned        BAR_IDX = 0,
  parameter int unsigned        ADR_W   = 9,
  parameter int unsigned        NREG    = 4,
  parameter int unsigned        NSTAT   = 2,
  parameter int unsigned        DB_ADR  = 'h100,
  parameter logic [NREG*16-1:0] CTL_RST = '0
) (
  input  logic                clk_125,
  input  logic                sys_rst_n,
  input  logic [6:0]          slv_bar_i,
  input  logic                slv_ce_i,
  input  logic                slv_we_i,
  input  logic [19:1]         slv_adr_i,
  input  logic [15:0]         slv_dat_i,
  input  logic [1:0]          slv_sel_i,
  output logic [15:0]         slv_dat_o,
  output logic [NREG*16-1:0]  ctl_o,
  input  logic [NSTAT*16-1:0] sts_i,
  output logic                db_req_o,
  output logic [15:0]         db_dat_o,
  input  logic                db_ack_i,
  input  logic [15:0]         irq_src_i,
  output logic                irq_o
);

  localparam logic [ADR_W-1:0] DB_A = ADR_W'(DB_ADR);

  logic [ADR_W-1:0]   a;
  logic               acc, wr, rd, db_wr, db_rd, db_accept, db_reject;
  logic [15:0]        be;

  logic [NREG*16-1:0] ctl_q, ctl_d;
  logic [15:0]        rd_q, rd_d;
  logic               db_req_q, db_req_d;
  logic [15:0]        db_dat_q, db_dat_d;
  logic               ovr_q, ovr_d;
  logic [11:0]        db_cnt_q, db_cnt_d;

  assign a         = slv_adr_i[ADR_W:1];
  assign acc       = slv_ce_i & slv_bar_i[BAR_IDX];
  assign wr        = acc & slv_we_i;
  assign rd        = acc & ~slv_we_i;
  assign be        = {{8{slv_sel_i[1]}}, {8{slv_sel_i[0]}}};
  assign db_wr     = wr & (a == DB_A);
  assign db_rd     = rd & (a == DB_A);
  // A pending doorbell can be replaced only when the consumer acks in the same cycle.
  assign db_accept = db_wr & (~db_req_q | db_ack_i);
  assign db_reject = db_wr & db_req_q & ~db_ack_i;

`ifdef SLV_REGFILE_IRQ_EN
  localparam logic [ADR_W-1:0] IRQ_STAT_A = ADR_W'(DB_ADR + 1);
  localparam logic [ADR_W-1:0] IRQ_MASK_A = ADR_W'(DB_ADR + 2);

  logic [15:0] irq_stat_q, irq_stat_d;
  logic [15:0] irq_mask_q, irq_mask_d;
  logic        irq_q;
  logic        unused_ok;

  assign irq_o     = irq_q;
  assign unused_ok = ^{slv_adr_i, slv_bar_i};
`else
  logic unused_ok;

  assign irq_o     = 1'b0;
  assign unused_ok = ^{slv_adr_i, slv_bar_i, irq_src_i};
`endif

  always_comb begin
    ctl_d    = ctl_q;
    rd_d     = rd_q;
    db_req_d = db_req_q;
    db_dat_d = db_dat_q;
    ovr_d    = ovr_q;
    db_cnt_d = db_cnt_q;
`ifdef SLV_REGFILE_IRQ_EN
    irq_stat_d = irq_stat_q;
    irq_mask_d = irq_mask_q;
`endif

    if (rd) begin
      rd_d = slv_adr_i[16:1];
      for (int k = 0; k < int'(NREG); k++)
        if (a == ADR_W'(k)) rd_d = ctl_q[16*k +: 16];
      for (int k = 0; k < int'(NSTAT); k++)
        if (a == ADR_W'(int'(NREG) + k)) rd_d = sts_i[16*k +: 16];
      if (a == DB_A) rd_d = {db_req_q, ovr_q, 2'b00, db_cnt_q};
`ifdef SLV_REGFILE_IRQ_EN
      if (a == IRQ_STAT_A) rd_d = irq_stat_q;
      if (a == IRQ_MASK_A) rd_d = irq_mask_q;
`endif
    end

    if (wr) begin
      for (int k = 0; k < int'(NREG); k++)
        if (a == ADR_W'(k)) ctl_d[16*k +: 16] = (ctl_q[16*k +: 16] & ~be) | (slv_dat_i & be);
    end

    if (db_accept) begin
      db_req_d = 1'b1;
      db_dat_d = slv_dat_i;
      db_cnt_d = db_cnt_q + 12'd1;
    end else if (db_ack_i) begin
      db_req_d = 1'b0;
    end

    // Set beats the read-to-clear when both land in one cycle.
    if (db_rd)     ovr_d = 1'b0;
    if (db_reject) ovr_d = 1'b1;

`ifdef SLV_REGFILE_IRQ_EN
    if (wr && a == IRQ_STAT_A) irq_stat_d = irq_stat_q & ~(slv_dat_i & be);
    irq_stat_d = irq_stat_d | irq_src_i;
    if (wr && a == IRQ_MASK_A) irq_mask_d = (irq_mask_q & ~be) | (slv_dat_i & be);
`endif
  end

  always_ff @(posedge clk_125) begin
    if (!sys_rst_n) begin
      ctl_q    <= CTL_RST;
      rd_q     <= '0;
      db_req_q <= 1'b0;
      db_dat_q <= '0;
      ovr_q    <= 1'b0;
      db_cnt_q <= '0;
`ifdef SLV_REGFILE_IRQ_EN
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      ctl_q    <= ctl_d;
      rd_q     <= rd_d;
      db_req_q <= db_req_d;
      db_dat_q <= db_dat_d;
      ovr_q    <= ovr_d;
      db_cnt_q <= db_cnt_d;
`ifdef SLV_REGFILE_IRQ_EN
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= |(irq_stat_q & irq_mask_q);
`endif
    end
  end

  assign ctl_o     = ctl_q;
  assign db_req_o  = db_req_q;
  assign db_dat_o  = db_dat_q;
  assign slv_dat_o = slv_bar_i[BAR_IDX] ? rd_q : 16'h0000;

endmodule

// File: tb/tb_slv_regfile.sv
// Self-checking bench for slv_regfile: directed test-plan steps plus randomized traffic against a reference model.
module tb_slv_regfile;

  localparam logic [63:0] CTL_RST = {16'h3fff, 48'h0};

  logic        clk_125 = 1'b0;
  logic        sys_rst_n;
  logic [6:0]  slv_bar_i;
  logic        slv_ce_i, slv_we_i;
  logic [19:1] slv_adr_i;
  logic [15:0] slv_dat_i;
  logic [1:0]  slv_sel_i;
  logic [15:0] slv_dat_o;
  logic [63:0] ctl_o;
  logic [31:0] sts_i;
  logic        db_req_o;
  logic [15:0] db_dat_o;
  logic        db_ack_i;
  logic [15:0] irq_src_i;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain per-register values.
  logic [15:0] m_ctl [4];
  logic [15:0] m_rd, m_dat, m_stat, m_mask;
  bit          m_pend, m_ovr, m_irq;
  int          m_cnt;

  slv_regfile #(
    .BAR_IDX(0), .ADR_W(9), .NREG(4), .NSTAT(2), .DB_ADR('h100), .CTL_RST(CTL_RST)
  ) dut (
    .clk_125(clk_125), .sys_rst_n(sys_rst_n), .slv_bar_i(slv_bar_i), .slv_ce_i(slv_ce_i),
    .slv_we_i(slv_we_i), .slv_adr_i(slv_adr_i), .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i),
    .slv_dat_o(slv_dat_o), .ctl_o(ctl_o), .sts_i(sts_i), .db_req_o(db_req_o),
    .db_dat_o(db_dat_o), .db_ack_i(db_ack_i), .irq_src_i(irq_src_i), .irq_o(irq_o)
  );

  always #4 clk_125 = ~clk_125;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bytes_of(input logic [1:0] s);
    return {{8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_edge();
    logic [8:0]  a;
    bit          rd, wr, ovr_set;
    logic [15:0] m;
    bit          nirq;
    if (!sys_rst_n) begin
      for (int k = 0; k < 4; k++) m_ctl[k] = CTL_RST[16*k +: 16];
      m_rd = 0; m_dat = 0; m_stat = 0; m_mask = 0;
      m_pend = 0; m_ovr = 0; m_irq = 0; m_cnt = 0;
      return;
    end
    a       = slv_adr_i[9:1];
    rd      = slv_ce_i && slv_bar_i[0] && !slv_we_i;
    wr      = slv_ce_i && slv_bar_i[0] && slv_we_i;
    m       = bytes_of(slv_sel_i);
    ovr_set = 0;
    nirq    = |(m_stat & m_mask);
    if (rd) begin
      if (a < 4)                m_rd = m_ctl[a];
      else if (a < 6)           m_rd = sts_i[16*(int'(a)-4) +: 16];
      else if (a == 9'h100)     m_rd = {m_pend, m_ovr, 2'b00, 12'(m_cnt)};
`ifdef SLV_REGFILE_IRQ_EN
      else if (a == 9'h101)     m_rd = m_stat;
      else if (a == 9'h102)     m_rd = m_mask;
`endif
      else                      m_rd = slv_adr_i[16:1];
    end
    if (wr && a < 4) m_ctl[a] = (m_ctl[a] & ~m) | (slv_dat_i & m);
    if (wr && a == 9'h100) begin
      if (!m_pend || db_ack_i) begin
        m_pend = 1; m_dat = slv_dat_i; m_cnt = (m_cnt + 1) % 4096;
      end else ovr_set = 1;
    end else if (db_ack_i) m_pend = 0;
    if (rd && a == 9'h100) m_ovr = 0;
    if (ovr_set) m_ovr = 1;
`ifdef SLV_REGFILE_IRQ_EN
    if (wr && a == 9'h101) m_stat = m_stat & ~(slv_dat_i & m);
    m_stat = m_stat | irq_src_i;
    if (wr && a == 9'h102) m_mask = (m_mask & ~m) | (slv_dat_i & m);
    m_irq = nirq;
`endif
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk_125);
    model_edge();
    @(negedge clk_125);
    check("slv_dat", slv_dat_o, slv_bar_i[0] ? m_rd : 16'h0);
    check("ctl", ctl_o, {m_ctl[3], m_ctl[2], m_ctl[1], m_ctl[0]});
    check("db_req", db_req_o, m_pend);
    check("db_dat", db_dat_o, m_dat);
    check("irq", irq_o, m_irq);
  endtask

  task automatic idle();
    slv_ce_i = 0; slv_we_i = 0; db_ack_i = 0; slv_bar_i = 7'h01;
  endtask

  task automatic access(input logic we, input logic [8:0] a, input logic [15:0] d,
                        input logic [1:0] s, input logic ack);
    slv_ce_i = 1; slv_we_i = we; slv_bar_i = 7'h01; slv_adr_i = {10'h0, a};
    slv_dat_i = d; slv_sel_i = s; db_ack_i = ack;
    step();
    idle();
  endtask

  initial begin
    logic [8:0] pick [8];
    pick = '{9'h000, 9'h001, 9'h003, 9'h004, 9'h005, 9'h100, 9'h101, 9'h102};
    idle();
    sys_rst_n = 0; slv_adr_i = '0; slv_dat_i = '0; slv_sel_i = '0;
    sts_i = 32'h0; irq_src_i = '0;
    @(negedge clk_125);
    step(); step();
    check("rst_ctl", ctl_o, CTL_RST);
    check("rst_db_req", db_req_o, 1'b0);
    check("rst_dat_o", slv_dat_o, 16'h0);
    sys_rst_n = 1;

    access(0, 9'd3, 16'h0, 2'b00, 0);
    check("rd_ctl3", slv_dat_o, 16'h3fff);
    access(1, 9'd1, 16'hA5C3, 2'b01, 0);
    access(0, 9'd1, 16'h0, 2'b00, 0);
    check("rd_ctl1_be", slv_dat_o, 16'h00C3);

    sts_i = 32'h5678_1234;
    access(0, 9'd4, 16'h0, 2'b00, 0);
    check("rd_sts0", slv_dat_o, 16'h1234);
    slv_ce_i = 1; slv_we_i = 0; slv_adr_i = 19'h3C050;
    step(); idle();
    check("rd_echo", slv_dat_o, 16'hC050);
    slv_bar_i = 7'h02;
    step();
    check("bar_gate", slv_dat_o, 16'h0);
    idle();

    access(1, 9'h100, 16'hBEEF, 2'b11, 0);
    check("db_req_set", db_req_o, 1'b1);
    check("db_dat_beef", db_dat_o, 16'hBEEF);
    access(1, 9'h100, 16'h1111, 2'b00, 0);
    check("db_dat_kept", db_dat_o, 16'hBEEF);
    access(0, 9'h100, 16'h0, 2'b00, 0);
    check("db_rd1", slv_dat_o, 16'hC001);
    access(0, 9'h100, 16'h0, 2'b00, 0);
    check("db_rd2", slv_dat_o, 16'h8001);

    access(1, 9'h100, 16'h2222, 2'b10, 1);
    check("db_ack_wr_req", db_req_o, 1'b1);
    check("db_ack_wr_dat", db_dat_o, 16'h2222);
    for (int i = 0; i < 4093; i++) access(1, 9'h100, 16'(i), 2'b01, 1);
    access(0, 9'h100, 16'h0, 2'b00, 0);
    check("db_cnt_fff", slv_dat_o, 16'h8FFF);
    access(1, 9'h100, 16'h3333, 2'b11, 1);
    access(0, 9'h100, 16'h0, 2'b00, 0);
    check("db_cnt_wrap", slv_dat_o, 16'h8000);

    access(1, 9'd0, 16'h1234, 2'b11, 0);
    sys_rst_n = 0;
    step();
    sys_rst_n = 1;
    check("rst2_ctl", ctl_o, CTL_RST);
    check("rst2_db_req", db_req_o, 1'b0);
    check("rst2_db_dat", db_dat_o, 16'h0);
    check("rst2_dat_o", slv_dat_o, 16'h0);
    check("rst2_irq", irq_o, 1'b0);

    access(1, 9'h102, 16'h0004, 2'b11, 0);
    irq_src_i = 16'h0004;
    step();
    irq_src_i = 16'h0;
    check("irq_lag", irq_o, 1'b0);
    step();
`ifdef SLV_REGFILE_IRQ_EN
    check("irq_on", irq_o, 1'b1);
`else
    check("irq_off", irq_o, 1'b0);
`endif
    access(1, 9'h101, 16'h0004, 2'b01, 0);
    step();
    check("irq_cleared", irq_o, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      slv_ce_i  = 1'($urandom_range(0, 1));
      slv_we_i  = 1'($urandom_range(0, 1));
      slv_bar_i = ($urandom_range(0, 7) == 0) ? 7'h7E & 7'($urandom) : 7'h01 | 7'($urandom);
      slv_adr_i = 19'($urandom);
      if ($urandom_range(0, 3) != 0) slv_adr_i[9:1] = pick[$urandom_range(0, 7)];
      slv_dat_i = 16'($urandom);
      slv_sel_i = 2'($urandom);
      db_ack_i  = ($urandom_range(0, 3) == 0);
      sts_i     = $urandom;
      irq_src_i = ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      sys_rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    sys_rst_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slv_regfile.md
Name: slv_regfile

Overview:
- Parametrised BAR-mapped register block on the 16-bit PCIe slave bus of pcie_tlp; replaces hand-written per-address decode in board tops.
- Provides NREG read/write control registers with byte enables, NSTAT read-only status words and a doorbell with a request/acknowledge handshake, pending flag, overrun flag and counter.
- Read data is registered and BAR-gated, so several instances and RAMs can be ORed onto slv_dat_o.

Parameters:
- BAR_IDX, 0, slv_bar_i bit this instance responds to.
- ADR_W, 9, number of word-address bits decoded (slv_adr_i[ADR_W:1]).
- NREG, 4, number of RW control registers at word addresses 0..NREG-1.
- NSTAT, 2, number of RO status words at word addresses NREG..NREG+NSTAT-1.
- DB_ADR, 9'h100, doorbell word address; must satisfy NREG+NSTAT <= DB_ADR < 2**ADR_W-2.
- CTL_RST, {NREG*16{1'b0}}, reset value of the control registers (register k = bits [16k+15:16k]).

Ports:
- clk_125 input 1: sole clock.
- sys_rst_n input 1: synchronous reset, active low.
- slv_bar_i input 7: BAR hit vector.
- slv_ce_i input 1: access strobe, one cycle per access.
- slv_we_i input 1: 1 = write, 0 = read.
- slv_adr_i input 19 ([19:1]): word address.
- slv_dat_i input 16: write data.
- slv_sel_i input 2: byte enables; [0] = bits 7:0, [1] = bits 15:8.
- slv_dat_o output 16: read data, gated by slv_bar_i[BAR_IDX].
- ctl_o output NREG*16: control register contents.
- sts_i input NSTAT*16: status words, sampled on read.
- db_req_o output 1: doorbell pending; held until acknowledged.
- db_dat_o output 16: data captured by the last accepted doorbell write.
- db_ack_i input 1: single-cycle acknowledge from the consumer.
- irq_src_i input 16: interrupt sources (used only with the optional feature).
- irq_o output 1: interrupt output (used only with the optional feature).

Behaviour:
- Clock and reset: single clock clk_125. Reset is synchronous, active-low on sys_rst_n.
- Reset values: ctl_o = CTL_RST, rd_q = 0, db_req_o = 0, db_dat_o = 0, overrun = 0, db_cnt = 0, irq_o = 0.
- Access: occurs when slv_ce_i & slv_bar_i[BAR_IDX]; decode uses a = slv_adr_i[ADR_W:1]. Upper address bits are ignored (aliasing is intended).
- Write, a < NREG: update ctl register a per byte enable. sel = 0 is a no-op.
- Write, status range or unmapped address: ignored.
- Read latency: rd_q is loaded the cycle after the access. It holds its value when there is no read access.
- Read sources:
  - a < NREG: ctl[a].
  - status range: sts_i word (a-NREG).
  - a = DB_ADR: {db_req_o, overrun, 2'b00, db_cnt[11:0]}.
  - unmapped: slv_adr_i[16:1] (debug echo).
- Output gating: slv_dat_o = slv_bar_i[BAR_IDX] ? rd_q : 16'h0, combinational.
- Doorbell write: a = DB_ADR, any sel value, including 0.
  - Accepted when db_req_o = 0 or db_ack_i = 1 in the same cycle. On accept: db_req_o <= 1, db_dat_o <= slv_dat_i (byte enables ignored), db_cnt <= db_cnt + 1 (12-bit, wraps 0xFFF -> 0x000).
  - Rejected when db_req_o = 1 and db_ack_i = 0. On reject: overrun <= 1; db_dat_o and db_cnt unchanged.
- db_ack_i with no doorbell write: db_req_o <= 0. db_ack_i while db_req_o = 0 is ignored.
- Overrun is read-to-clear: a read of DB_ADR returns the current value and clears it the next cycle. If a rejected write lands in the same cycle as that read, set wins.
- Bus stalls: none. Every access completes in one cycle, and back-to-back accesses are supported.
- Reset during a pending doorbell: drops db_req_o with no acknowledge required.

Optional Feature:
- Macro: SLV_REGFILE_IRQ_EN.
- When defined, word addresses DB_ADR+1 and DB_ADR+2 are mapped:
  - DB_ADR+1: irq_stat, 16 sticky bits. Each bit is set by irq_src_i[n] = 1 and cleared by writing 1 to it (byte-enabled W1C). If set and clear hit the same cycle, set wins.
  - DB_ADR+2: irq_mask, RW, resets to 0.
  - irq_o is registered: irq_o <= |(irq_stat & irq_mask), one cycle after the status/mask change.
- When undefined: both addresses read as unmapped (address echo), writes to them are ignored, irq_o is tied 0 and irq_src_i is unused.

Test Plan:
- Reset with NREG=4, CTL_RST={16'h3fff,48'h0}: ctl register 3 reads 16'h3fff and db_req_o = 0. Write 16'hA5C3 to address 1 with sel=2'b01: read of address 1 returns 16'h00C3 exactly one cycle after the access strobe.
- Read of status address 4 with sts_i word0 = 16'h1234 returns 16'h1234. Read of unmapped address 9'h050 returns slv_adr_i[16:1]. With slv_bar_i[BAR_IDX] = 0, slv_dat_o = 0.
- Doorbell write 16'hBEEF: db_req_o = 1, db_dat_o = 16'hBEEF, db_cnt = 1. A second write 16'h1111 before ack leaves db_dat_o = 16'hBEEF and sets overrun. Reading DB_ADR returns 16'hC001, and a second read returns 16'h8001.
- Doorbell write in the same cycle as db_ack_i while pending: accepted, db_req_o stays 1, new data is captured and db_cnt increments. db_cnt preset to 0xFFF by 4095 writes wraps to 0x000 on the next accepted write.
- Deassert sys_rst_n for one cycle with the doorbell pending and ctl modified: all outputs return to their reset values on the following edge.
- With SLV_REGFILE_IRQ_EN: set irq_mask = 16'h0004 and pulse irq_src_i[2] -> irq_o = 1 one cycle after the status bit sets. Write 16'h0004 to DB_ADR+1 -> irq_o = 0. Without the macro, irq_o stays 0 throughout.
